// File: rtl/counter_nbits_updown_en_if.sv
// Control and status bundle for counter_nbits_updown_en.
// The master drives the controls and the slave (the counter) drives the status.
interface counter_nbits_updown_en_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en_in;
    logic             up_in;
    logic             oneshot_in;
    logic             clear_in;
    logic             load_in;
    logic [WIDTH-1:0] load_val_in;
    logic [WIDTH-1:0] count_out;
    logic [WIDTH-1:0] gray_out;
    logic             tc_out;
    logic             wrap_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output en_in, up_in, oneshot_in, clear_in, load_in, load_val_in,
        input  count_out, gray_out, tc_out, wrap_out, busy_out, done_out
    );

    modport slave (
        input  en_in, up_in, oneshot_in, clear_in, load_in, load_val_in,
        output count_out, gray_out, tc_out, wrap_out, busy_out, done_out
    );
endinterface

// File: rtl/counter_nbits_updown_en.sv
// Modulo-MODULUS up/down counter with an IDLE/RUN/DONE state machine.
// Supports clear, saturating load, one-shot stop, a wrap pulse and a Gray-coded count.
module counter_nbits_updown_en #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input logic                     clk,
    input logic                     reset_al_in,
    counter_nbits_updown_en_if.slave bus
);
    typedef enum logic [1:0] {StIdle = 2'b00, StRun = 2'b01, StDone = 2'b10} state_e;

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;

    logic             at_max;
    logic             at_zero;
    logic             step_wraps;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_sat;

    always_comb begin
        at_max     = (count_q == MaxCount);
        at_zero    = (count_q == '0);
        step_wraps = 1'b0;
        step_val   = count_q;
        if (bus.up_in) begin
            step_wraps = at_max;
            step_val   = at_max ? '0 : count_q + 1'b1;
        end else begin
            step_wraps = at_zero;
            step_val   = at_zero ? MaxCount : count_q - 1'b1;
        end
        // Out-of-range loads clamp so the count never leaves 0..MODULUS-1.
        load_sat = (32'(bus.load_val_in) > (MODULUS - 1)) ? MaxCount : bus.load_val_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_al_in) begin
            state_q <= StIdle;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.clear_in) begin
            state_q <= StIdle;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.load_in) begin
            state_q <= StIdle;
            count_q <= load_sat;
            wrap_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StRun: begin
                    if (bus.en_in) begin
                        if (step_wraps && bus.oneshot_in) begin
                            // Terminal value is already in count_q; freeze there.
                            state_q <= StDone;
                            wrap_q  <= 1'b0;
                        end else begin
                            state_q <= StRun;
                            count_q <= step_val;
                            wrap_q  <= step_wraps;
                        end
                    end else begin
                        state_q <= StIdle;
                        wrap_q  <= 1'b0;
                    end
                end
                StDone: begin
                    wrap_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    wrap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count_out = count_q;
    assign bus.gray_out  = count_q ^ (count_q >> 1);
    assign bus.tc_out    = bus.up_in ? at_max : at_zero;
    assign bus.wrap_out  = wrap_q;
    assign bus.busy_out  = (state_q == StRun);
    assign bus.done_out  = (state_q == StDone);
endmodule

// File: tb/tb_counter_nbits_updown_en.sv
// Directed bench: a MODULUS=16 counter for the full count-through and mid-run reset,
// and a MODULUS=10 counter driven from a vector table.
module tb_counter_nbits_updown_en;
    logic clk;
    logic reset_al_in;

    counter_nbits_updown_en_if #(.WIDTH(4)) b16 ();
    counter_nbits_updown_en_if #(.WIDTH(4)) b10 ();

    counter_nbits_updown_en #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .bus         (b16)
    );

    counter_nbits_updown_en #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .bus         (b10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic       os;
        logic [3:0] c;
        logic       w;
        logic       tc;
        logic       b;
        logic       d;
    } vec_t;

    localparam int NVec = 26;
    vec_t tbl [NVec];

    task automatic idle_inputs();
        b16.en_in = 0; b16.up_in = 0; b16.oneshot_in = 0;
        b16.clear_in = 0; b16.load_in = 0; b16.load_val_in = '0;
        b10.en_in = 0; b10.up_in = 0; b10.oneshot_in = 0;
        b10.clear_in = 0; b10.load_in = 0; b10.load_val_in = '0;
    endtask

    logic [3:0] exp_c;
    logic [3:0] prev_g;
    logic [3:0] gdiff;

    initial begin
        //             rst clr ld lv  en up os   c  w tc b d
        tbl[0]  = '{1, 0, 1, 4'd3,  0, 0, 0, 4'd3, 0, 0, 0, 0}; // load 3
        tbl[1]  = '{1, 0, 0, 4'd0,  1, 0, 0, 4'd2, 0, 0, 1, 0};
        tbl[2]  = '{1, 0, 0, 4'd0,  1, 0, 0, 4'd1, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 4'd0,  1, 0, 0, 4'd0, 0, 1, 1, 0};
        tbl[4]  = '{1, 0, 0, 4'd0,  1, 0, 0, 4'd9, 1, 0, 1, 0}; // down wrap
        tbl[5]  = '{1, 0, 0, 4'd0,  1, 0, 0, 4'd8, 0, 0, 1, 0};
        tbl[6]  = '{1, 0, 1, 4'd7,  0, 1, 1, 4'd7, 0, 0, 0, 0}; // one-shot up
        tbl[7]  = '{1, 0, 0, 4'd0,  1, 1, 1, 4'd8, 0, 0, 1, 0};
        tbl[8]  = '{1, 0, 0, 4'd0,  1, 1, 1, 4'd9, 0, 1, 1, 0};
        tbl[9]  = '{1, 0, 0, 4'd0,  1, 1, 1, 4'd9, 0, 1, 0, 1};
        tbl[10] = '{1, 0, 0, 4'd0,  1, 1, 1, 4'd9, 0, 1, 0, 1};
        tbl[11] = '{1, 0, 0, 4'd0,  1, 0, 0, 4'd9, 0, 0, 0, 1}; // frozen in DONE
        tbl[12] = '{1, 0, 1, 4'd2,  1, 1, 0, 4'd2, 0, 0, 0, 0}; // load exits DONE
        tbl[13] = '{1, 0, 1, 4'd13, 0, 1, 0, 4'd9, 0, 1, 0, 0}; // saturate
        tbl[14] = '{1, 1, 1, 4'd5,  0, 1, 0, 4'd0, 0, 0, 0, 0}; // clear beats load
        tbl[15] = '{1, 0, 1, 4'd4,  0, 1, 0, 4'd4, 0, 0, 0, 0};
        tbl[16] = '{0, 0, 1, 4'd7,  0, 1, 0, 4'd0, 0, 0, 0, 0}; // reset beats load
        tbl[17] = '{1, 0, 1, 4'd5,  0, 1, 0, 4'd5, 0, 0, 0, 0}; // enable gating
        tbl[18] = '{1, 0, 0, 4'd0,  1, 1, 0, 4'd6, 0, 0, 1, 0};
        tbl[19] = '{1, 0, 0, 4'd0,  0, 1, 0, 4'd6, 0, 0, 0, 0};
        tbl[20] = '{1, 0, 0, 4'd0,  1, 0, 0, 4'd5, 0, 0, 1, 0};
        tbl[21] = '{1, 0, 1, 4'd9,  0, 1, 0, 4'd9, 0, 1, 0, 0};
        tbl[22] = '{1, 1, 0, 4'd0,  1, 1, 0, 4'd0, 0, 0, 0, 0}; // clear during wrap
        tbl[23] = '{1, 0, 1, 4'd0,  0, 0, 0, 4'd0, 0, 1, 0, 0};
        tbl[24] = '{1, 0, 0, 4'd0,  1, 0, 1, 4'd0, 0, 1, 0, 1}; // one-shot down
        tbl[25] = '{1, 1, 0, 4'd0,  0, 0, 0, 4'd0, 0, 1, 0, 0};

        idle_inputs();
        reset_al_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count16", 32'(b16.count_out), 32'd0);
        chk("rst_gray16",  32'(b16.gray_out),  32'd0);
        chk("rst_wrap16",  32'(b16.wrap_out),  32'd0);
        chk("rst_busy16",  32'(b16.busy_out),  32'd0);
        chk("rst_done16",  32'(b16.done_out),  32'd0);
        chk("rst_tc_down16", 32'(b16.tc_out),  32'd1);
        chk("rst_count10", 32'(b10.count_out), 32'd0);
        b16.up_in = 1'b1;
        #1;
        chk("rst_tc_up16", 32'(b16.tc_out), 32'd0);

        // Count-through with wrap on the 16-state counter.
        @(negedge clk);
        reset_al_in = 1'b1;
        b16.en_in = 1'b1;
        prev_g = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            exp_c = 4'(k % 16);
            chk("cnt16", 32'(b16.count_out), 32'(exp_c));
            chk("gray16", 32'(b16.gray_out), 32'(exp_c ^ (exp_c >> 1)));
            chk("wrap16", 32'(b16.wrap_out), (k == 16) ? 32'd1 : 32'd0);
            chk("tc16", 32'(b16.tc_out), (exp_c == 4'd15) ? 32'd1 : 32'd0);
            gdiff = b16.gray_out ^ prev_g;
            chk("gray16_onebit", 32'($countones(gdiff)), 32'd1);
            prev_g = b16.gray_out;
        end
        chk("busy16", 32'(b16.busy_out), 32'd1);

        // Advance to 12, then reset for one edge.
        repeat (12) @(posedge clk);
        #1;
        chk("cnt16_at12", 32'(b16.count_out), 32'd12);
        @(negedge clk);
        reset_al_in = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_count", 32'(b16.count_out), 32'd0);
        chk("midrst_busy",  32'(b16.busy_out),  32'd0);
        chk("midrst_done",  32'(b16.done_out),  32'd0);
        chk("midrst_wrap",  32'(b16.wrap_out),  32'd0);
        chk("midrst_tc",    32'(b16.tc_out),    32'd0);
        @(negedge clk);
        reset_al_in = 1'b1;
        b16.en_in = 1'b0;

        // Table-driven vectors on the MODULUS=10 counter.
        for (int i = 0; i < NVec; i++) begin
            @(negedge clk);
            reset_al_in     = tbl[i].rst;
            b10.clear_in    = tbl[i].clr;
            b10.load_in     = tbl[i].ld;
            b10.load_val_in = tbl[i].lv;
            b10.en_in       = tbl[i].en;
            b10.up_in       = tbl[i].up;
            b10.oneshot_in  = tbl[i].os;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), 32'(b10.count_out), 32'(tbl[i].c));
            chk($sformatf("v%0d_gray", i), 32'(b10.gray_out), 32'(tbl[i].c ^ (tbl[i].c >> 1)));
            chk($sformatf("v%0d_wrap", i), 32'(b10.wrap_out), 32'(tbl[i].w));
            chk($sformatf("v%0d_tc", i),   32'(b10.tc_out),   32'(tbl[i].tc));
            chk($sformatf("v%0d_busy", i), 32'(b10.busy_out), 32'(tbl[i].b));
            chk($sformatf("v%0d_done", i), 32'(b10.done_out), 32'(tbl[i].d));
        end

        // tc follows up_in without a clock edge; count is 0 here.
        @(negedge clk);
        reset_al_in = 1'b1;
        b10.clear_in = 0; b10.load_in = 0; b10.en_in = 0; b10.oneshot_in = 0;
        b10.up_in = 1'b1;
        #1;
        chk("tc_comb_up", 32'(b10.tc_out), 32'd0);
        b10.up_in = 1'b0;
        #1;
        chk("tc_comb_down", 32'(b10.tc_out), 32'd1);

        // Free-running down count from 0 never leaves 0..9.
        b10.en_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk("range10", 32'(b10.count_out < 4'd10), 32'd1);
        end
        chk("range10_end", 32'(b10.count_out), 32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
